// File: rtl/sram_bist_pkg.sv
// Shared types for the SRAM built-in self-test controller.
package sram_bist_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRead,
    StDrain,
    StDone
  } state_e;

  localparam logic [1:0] PAT_ADDR  = 2'd0;
  localparam logic [1:0] PAT_RADDR = 2'd1;
  localparam logic [1:0] PAT_CHK   = 2'd2;
  localparam logic [1:0] PAT_SEED  = 2'd3;

endpackage

// File: rtl/sram_bist_if.sv
// Single-port SRAM bus as seen between the BIST controller and the Gowin_SP macro.
interface sram_bist_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) ();

  logic              mem_ce;
  logic              mem_wre;
  logic              mem_oce;
  logic              mem_reset;
  logic [ADDR_W-1:0] mem_ad;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport master (
    output mem_ce, mem_wre, mem_oce, mem_reset, mem_ad, mem_din,
    input  mem_dout
  );

  modport slave (
    input  mem_ce, mem_wre, mem_oce, mem_reset, mem_ad, mem_din,
    output mem_dout
  );

endinterface

// File: rtl/sram_bist_patgen.sv
// Test pattern generator: maps (pattern, seed, address) to the word written/expected.
module sram_bist_patgen import sram_bist_pkg::*; #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic [1:0]        pattern_sel,
  input  logic [DATA_W-1:0] seed,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  localparam int unsigned WideW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

  logic [ADDR_W-1:0] raddr;
  logic [WideW-1:0]  addr_wide;
  logic [WideW-1:0]  raddr_wide;
  logic [DATA_W-1:0] chk;

  // DEPTH-1-addr is the bitwise complement over ADDR_W bits.
  assign raddr      = ~addr;
  assign addr_wide  = WideW'(addr);
  assign raddr_wide = WideW'(raddr);

  always_comb begin
    chk = '0;
    for (int i = 0; i < DATA_W; i++) begin
      chk[i] = (((i % 2) == 1) == addr[0]);
    end
  end

  always_comb begin
    data = '0;
    unique case (pattern_sel)
      PAT_ADDR:  data = addr_wide[DATA_W-1:0];
      PAT_RADDR: data = raddr_wide[DATA_W-1:0];
      PAT_CHK:   data = chk;
      PAT_SEED:  data = seed ^ addr_wide[DATA_W-1:0];
    endcase
  end

endmodule

// File: rtl/sram_bist_ctrl.sv
// SRAM BIST initiator: write-then-readback (or readback-only) sweep with pipelined compare.
module sram_bist_ctrl import sram_bist_pkg::*; #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              verify_only,
  input  logic [1:0]        pattern_sel,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  sram_bist_if.master       mem
);

  localparam logic [ADDR_W-1:0] LastAddr = '1;

  state_e            state_q, state_d;
  logic [1:0]        pat_q, pat_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic              ce_q, ce_d, wre_q, wre_d;
  logic [ADDR_W-1:0] ad_q, ad_d;
  logic [DATA_W-1:0] din_q, din_d, wdata, exp_data;
  logic              cmp_valid_q, cmp_valid_d;
  logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
  logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [ADDR_W:0]   err_q, err_d;
  logic [ADDR_W-1:0] first_q, first_d;
  logic              mismatch;

  // Write data follows the next-state address so mem_din is registered alongside mem_ad.
  sram_bist_patgen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr_pat (
    .pattern_sel (pat_d),
    .seed        (seed_d),
    .addr        (ad_d),
    .data        (wdata)
  );

  sram_bist_patgen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_exp_pat (
    .pattern_sel (pat_q),
    .seed        (seed_q),
    .addr        (cmp_addr_q),
    .data        (exp_data)
  );

  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    seed_d      = seed_q;
    ad_d        = ad_q;
    err_d       = err_q;
    first_d     = first_q;
    pass_d      = pass_q;
    // Stage 2 of the read pipeline: the address presented last cycle returns data next cycle.
    cmp_valid_d = (state_q == StRead);
    cmp_addr_d  = ad_q;
    mismatch    = cmp_valid_q && (mem.mem_dout != exp_data);

    if (mismatch) begin
      err_d = err_q + 1'b1;
      if (err_q == '0) begin
        first_d = cmp_addr_q;
      end
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = verify_only ? StRead : StWrite;
          pat_d   = pattern_sel;
          seed_d  = seed;
          ad_d    = '0;
          err_d   = '0;
          first_d = '0;
          pass_d  = 1'b0;
        end
      end
      StWrite: begin
        if (ad_q == LastAddr) begin
          state_d = StRead;
          ad_d    = '0;
        end else begin
          ad_d = ad_q + 1'b1;
        end
      end
      StRead: begin
        if (ad_q == LastAddr) begin
          state_d = StDrain;
        end else begin
          ad_d = ad_q + 1'b1;
        end
      end
      StDrain: begin
        state_d = StDone;
        pass_d  = (err_d == '0);
      end
      default: state_d = StIdle;
    endcase

    ce_d   = state_d inside {StWrite, StRead};
    wre_d  = (state_d == StWrite);
    busy_d = state_d inside {StWrite, StRead, StDrain};
    done_d = (state_q == StDrain);
  end

  assign din_d = wre_d ? wdata : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      pat_q       <= '0;
      seed_q      <= '0;
      ce_q        <= 1'b0;
      wre_q       <= 1'b0;
      ad_q        <= '0;
      din_q       <= '0;
      cmp_valid_q <= 1'b0;
      cmp_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      first_q     <= '0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      seed_q      <= seed_d;
      ce_q        <= ce_d;
      wre_q       <= wre_d;
      ad_q        <= ad_d;
      din_q       <= din_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_addr_q  <= cmp_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      first_q     <= first_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;

  assign mem.mem_ce    = ce_q;
  assign mem.mem_wre   = wre_q;
  assign mem.mem_oce   = 1'b1;
  assign mem.mem_reset = 1'b0;
  assign mem.mem_ad    = ad_q;
  assign mem.mem_din   = din_q;

endmodule

// File: tb/tb_sram_bist_ctrl.sv
// Self-checking bench for sram_bist_ctrl with a behavioural 16x8 bypass-mode SRAM.
module tb_sram_bist_ctrl;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int BOUND = 100;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       verify_only = 1'b0;
  logic [1:0] pattern_sel = 2'd0;
  logic [7:0] seed = 8'h00;
  logic       busy, done, pass;
  logic [4:0] err_count;
  logic [3:0] first_err_addr;

  sram_bist_if #(.ADDR_W(AW), .DATA_W(DW)) mem_bus ();

  sram_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .verify_only    (verify_only),
    .pattern_sel    (pattern_sel),
    .seed           (seed),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .mem            (mem_bus)
  );

  always #5 clk = ~clk;

  // SRAM model: 1-cycle read latency, write-through on writes, optional stuck-at-0 bits on read.
  logic [7:0] sram     [DEPTH];
  logic [7:0] init_img [DEPTH];
  logic [7:0] img      [DEPTH];
  logic       load_req = 1'b0;
  logic [7:0] stuck_mask = 8'h00;
  logic [7:0] dout_r = 8'h00;

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < DEPTH; i++) sram[i] <= init_img[i];
    end else if (mem_bus.mem_ce) begin
      if (mem_bus.mem_wre) begin
        sram[mem_bus.mem_ad] <= mem_bus.mem_din;
        dout_r <= mem_bus.mem_din;
      end else begin
        dout_r <= sram[mem_bus.mem_ad] & ~stuck_mask;
      end
    end
  end
  assign mem_bus.mem_dout = dout_r;

  int          total = 0;
  int          bad = 0;
  int          lat;
  bit          timed_out;
  int          busy_bad;
  logic        pass_at0;
  logic [4:0]  err_at0;
  logic [13:0] obs [BOUND];
  logic [13:0] exp_q [$];

  function automatic logic [7:0] pat(input logic [1:0] sel, input logic [7:0] sd, input int a);
    case (sel)
      2'd0:    return 8'(a);
      2'd1:    return 8'(DEPTH - 1 - a);
      2'd2:    return (a % 2 == 1) ? 8'hAA : 8'h55;
      default: return sd ^ 8'(a);
    endcase
  endfunction

  function automatic logic [13:0] bus_word(input logic ce, input logic wre, input logic [3:0] ad,
                                           input logic [7:0] din);
    return {ce, wre, ce ? ad : 4'd0, wre ? din : 8'd0};
  endfunction

  // Expected bus activity: a write sweep (unless verify-only), a read sweep, one idle drain cycle.
  task automatic model_schedule(input logic vo, input logic [1:0] sel, input logic [7:0] sd);
    exp_q.delete();
    if (!vo) for (int a = 0; a < DEPTH; a++) exp_q.push_back(bus_word(1'b1, 1'b1, 4'(a), pat(sel, sd, a)));
    for (int a = 0; a < DEPTH; a++) exp_q.push_back(bus_word(1'b1, 1'b0, 4'(a), 8'h00));
    exp_q.push_back(bus_word(1'b0, 1'b0, 4'd0, 8'h00));
  endtask

  task automatic load_pulse();
    for (int i = 0; i < DEPTH; i++) init_img[i] = img[i];
    load_req = 1'b1;
    @(posedge clk);
    #1 load_req = 1'b0;
  endtask

  // Issues start, then observes each cycle until done (bounded). Returns in the done cycle.
  task automatic run_bist(input logic vo, input logic [1:0] sel, input logic [7:0] sd, input int extra_k);
    for (int k = 0; k < BOUND; k++) obs[k] = 'x;
    verify_only = vo;
    pattern_sel = sel;
    seed = sd;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    timed_out = 1'b1;
    busy_bad = 0;
    for (int k = 0; k < BOUND; k++) begin
      @(negedge clk);
      if (start) start = 1'b0;
      obs[k] = bus_word(mem_bus.mem_ce, mem_bus.mem_wre, mem_bus.mem_ad, mem_bus.mem_din);
      if (k == 0) begin
        pass_at0 = pass;
        err_at0 = err_count;
      end
      if (done === 1'b1) begin
        lat = k;
        timed_out = 1'b0;
        if (busy !== 1'b0) busy_bad++;
        break;
      end
      if (busy !== 1'b1) busy_bad++;
      if (k == extra_k) begin
        start = 1'b1;
        verify_only = ~vo;
        pattern_sel = sel + 2'd1;
        seed = ~sd;
      end
    end
  endtask

  task automatic test_reset();
    logic [25:0] got;
    reset_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    got = {busy, done, pass, err_count, first_err_addr, mem_bus.mem_ce, mem_bus.mem_wre,
           mem_bus.mem_ad, mem_bus.mem_din};
    total++;
    if (got !== 26'd0) begin
      bad++;
      $display("FAIL reset_state: got %h want %h", got, 26'd0);
    end
    total++;
    if ({mem_bus.mem_oce, mem_bus.mem_reset} !== 2'b10) begin
      bad++;
      $display("FAIL const_oce_reset: got %b want 10", {mem_bus.mem_oce, mem_bus.mem_reset});
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, mem_bus.mem_ce} !== 2'b00) begin
      bad++;
      $display("FAIL idle_quiet: got %b want 00", {busy, mem_bus.mem_ce});
    end
  endtask

  task automatic test_full_addr();
    int sb, fk;
    for (int a = 0; a < DEPTH; a++) img[a] = 8'h00;
    load_pulse();
    stuck_mask = 8'h00;
    model_schedule(1'b0, 2'd0, 8'h00);
    run_bist(1'b0, 2'd0, 8'h00, -1);
    sb = 0; fk = -1;
    for (int k = 0; k < exp_q.size(); k++) if (obs[k] !== exp_q[k]) begin sb++; if (fk < 0) fk = k; end
    total++;
    if (sb !== 0) begin
      bad++;
      $display("FAIL full_schedule: cycle %0d got %h want %h", fk, obs[fk], exp_q[fk]);
    end
    total++;
    if (lat !== 2 * DEPTH + 1) begin
      bad++;
      $display("FAIL full_latency: got %0d want %0d (timeout=%0b)", lat, 2 * DEPTH + 1, timed_out);
    end
    total++;
    if (busy_bad !== 0) begin
      bad++;
      $display("FAIL full_busy: got %0d bad cycles want 0", busy_bad);
    end
    total++;
    if ({pass, err_count, first_err_addr} !== {1'b1, 5'd0, 4'd0}) begin
      bad++;
      $display("FAIL full_result: got %b/%0d/%0d want 1/0/0", pass, err_count, first_err_addr);
    end
  endtask

  task automatic test_verify_only();
    int sb, fk;
    for (int a = 0; a < DEPTH; a++) img[a] = 8'(DEPTH - 1 - a);
    load_pulse();
    model_schedule(1'b1, 2'd1, 8'h3C);
    run_bist(1'b1, 2'd1, 8'h3C, -1);
    sb = 0; fk = -1;
    for (int k = 0; k < exp_q.size(); k++) if (obs[k] !== exp_q[k]) begin sb++; if (fk < 0) fk = k; end
    total++;
    if (sb !== 0) begin
      bad++;
      $display("FAIL vo_schedule: cycle %0d got %h want %h", fk, obs[fk], exp_q[fk]);
    end
    total++;
    if (lat !== DEPTH + 1) begin
      bad++;
      $display("FAIL vo_latency: got %0d want %0d", lat, DEPTH + 1);
    end
    total++;
    if ({pass, err_count} !== {1'b1, 5'd0}) begin
      bad++;
      $display("FAIL vo_result: got %b/%0d want 1/0", pass, err_count);
    end
  endtask

  task automatic test_stuck_bit();
    for (int a = 0; a < DEPTH; a++) img[a] = 8'h00;
    load_pulse();
    stuck_mask = 8'h08;
    run_bist(1'b0, 2'd2, 8'($urandom), -1);
    stuck_mask = 8'h00;
    total++;
    if ({lat, pass, err_count, first_err_addr} !== {2 * DEPTH + 1, 1'b0, 5'd8, 4'd1}) begin
      bad++;
      $display("FAIL stuck_result: got lat=%0d pass=%b err=%0d first=%0d want 33/0/8/1",
               lat, pass, err_count, first_err_addr);
    end
  endtask

  task automatic test_seed_corrupt();
    for (int a = 0; a < DEPTH; a++) img[a] = 8'hA5 ^ 8'(a);
    img[9] = img[9] ^ 8'h10;
    load_pulse();
    run_bist(1'b1, 2'd3, 8'hA5, -1);
    total++;
    if ({lat, pass, err_count, first_err_addr} !== {DEPTH + 1, 1'b0, 5'd1, 4'd9}) begin
      bad++;
      $display("FAIL seed_corrupt: got lat=%0d pass=%b err=%0d first=%0d want 17/0/1/9",
               lat, pass, err_count, first_err_addr);
    end
  endtask

  task automatic test_restart_ignored();
    int sb, fk;
    for (int a = 0; a < DEPTH; a++) img[a] = 8'h00;
    load_pulse();
    model_schedule(1'b0, 2'd1, 8'h00);
    run_bist(1'b0, 2'd1, 8'h00, 5);
    sb = 0; fk = -1;
    for (int k = 0; k < exp_q.size(); k++) if (obs[k] !== exp_q[k]) begin sb++; if (fk < 0) fk = k; end
    total++;
    if (sb !== 0) begin
      bad++;
      $display("FAIL restart_schedule: cycle %0d got %h want %h", fk, obs[fk], exp_q[fk]);
    end
    total++;
    if ({lat, pass, err_count} !== {2 * DEPTH + 1, 1'b1, 5'd0}) begin
      bad++;
      $display("FAIL restart_result: got lat=%0d pass=%b err=%0d want 33/1/0", lat, pass, err_count);
    end
  endtask

  task automatic test_reset_mid();
    logic [25:0] got;
    for (int a = 0; a < DEPTH; a++) img[a] = 8'h00;
    load_pulse();
    stuck_mask = 8'h08;
    verify_only = 1'b0;
    pattern_sel = 2'd2;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (DEPTH + 5) @(posedge clk);
    @(negedge clk);
    total++;
    if ({mem_bus.mem_ce, mem_bus.mem_wre, mem_bus.mem_ad, err_count, first_err_addr} !==
        {1'b1, 1'b0, 4'd5, 5'd2, 4'd1}) begin
      bad++;
      $display("FAIL read5_state: got ce=%b wre=%b ad=%0d err=%0d first=%0d want 1/0/5/2/1",
               mem_bus.mem_ce, mem_bus.mem_wre, mem_bus.mem_ad, err_count, first_err_addr);
    end
    reset_n = 1'b0;
    @(negedge clk);
    got = {busy, done, pass, err_count, first_err_addr, mem_bus.mem_ce, mem_bus.mem_wre,
           mem_bus.mem_ad, mem_bus.mem_din};
    total++;
    if (got !== 26'd0) begin
      bad++;
      $display("FAIL mid_reset: got %h want %h", got, 26'd0);
    end
    start = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, mem_bus.mem_ce} !== 2'b00) begin
      bad++;
      $display("FAIL reset_beats_start: got %b want 00", {busy, mem_bus.mem_ce});
    end
    start = 1'b0;
    reset_n = 1'b1;
    stuck_mask = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int sb, fk;
    for (int a = 0; a < DEPTH; a++) img[a] = 8'h00;
    load_pulse();
    run_bist(1'b0, 2'd0, 8'h00, -1);
    stuck_mask = 8'h08;
    run_bist(1'b0, 2'd2, 8'h00, -1);
    total++;
    if ({pass_at0, lat, err_count} !== {1'b0, 2 * DEPTH + 1, 5'd8}) begin
      bad++;
      $display("FAIL b2b_second: got pass0=%b lat=%0d err=%0d want 0/33/8", pass_at0, lat, err_count);
    end
    stuck_mask = 8'h00;
    model_schedule(1'b0, 2'd3, 8'h5A);
    run_bist(1'b0, 2'd3, 8'h5A, -1);
    sb = 0; fk = -1;
    for (int k = 0; k < exp_q.size(); k++) if (obs[k] !== exp_q[k]) begin sb++; if (fk < 0) fk = k; end
    total++;
    if (sb !== 0) begin
      bad++;
      $display("FAIL b2b_schedule: cycle %0d got %h want %h", fk, obs[fk], exp_q[fk]);
    end
    total++;
    if ({err_at0, lat, pass, err_count} !== {5'd0, 2 * DEPTH + 1, 1'b1, 5'd0}) begin
      bad++;
      $display("FAIL b2b_third: got err0=%0d lat=%0d pass=%b err=%0d want 0/33/1/0",
               err_at0, lat, pass, err_count);
    end
  endtask

  task automatic test_random();
    logic       vo;
    logic [1:0] sel;
    logic [7:0] sd, mask, content;
    int         n_bad, first, sb, fk, nc;
    for (int it = 0; it < 10; it++) begin
      vo = 1'($urandom % 2);
      sel = 2'($urandom % 4);
      sd = 8'($urandom);
      mask = ($urandom % 2 == 1) ? (8'h01 << ($urandom % 8)) : 8'h00;
      for (int a = 0; a < DEPTH; a++) img[a] = vo ? pat(sel, sd, a) : 8'($urandom);
      nc = vo ? int'($urandom % 3) : 0;
      for (int c = 0; c < nc; c++) begin
        fk = int'($urandom % DEPTH);
        img[fk] = img[fk] ^ 8'($urandom_range(1, 255));
      end
      load_pulse();
      stuck_mask = mask;
      n_bad = 0;
      first = 0;
      for (int a = 0; a < DEPTH; a++) begin
        content = vo ? img[a] : pat(sel, sd, a);
        if ((content & ~mask) != pat(sel, sd, a)) begin
          if (n_bad == 0) first = a;
          n_bad++;
        end
      end
      model_schedule(vo, sel, sd);
      run_bist(vo, sel, sd, -1);
      sb = 0; fk = -1;
      for (int k = 0; k < exp_q.size(); k++) if (obs[k] !== exp_q[k]) begin sb++; if (fk < 0) fk = k; end
      total++;
      if (sb !== 0) begin
        bad++;
        $display("FAIL rand_schedule[%0d]: cycle %0d got %h want %h", it, fk, obs[fk], exp_q[fk]);
      end
      total++;
      if ({lat, pass, err_count, first_err_addr} !==
          {exp_q.size(), n_bad == 0, 5'(n_bad), 4'(first)}) begin
        bad++;
        $display("FAIL rand_result[%0d]: got lat=%0d pass=%b err=%0d first=%0d want %0d/%b/%0d/%0d",
                 it, lat, pass, err_count, first_err_addr, exp_q.size(), n_bad == 0, n_bad, first);
      end
      stuck_mask = 8'h00;
    end
  endtask

  initial begin
    test_reset();
    test_full_addr();
    test_verify_only();
    test_stuck_bit();
    test_seed_corrupt();
    test_restart_ignored();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_bist_ctrl.md
Name: sram_bist_ctrl

Overview:
- Initiator for the single-port block SRAM: drives ce/wre/ad/din, consumes dout.
- Runs an on-demand write-then-readback test over the whole array, or a readback-only pass, and reports pass/fail, error count and first failing address.
- Sits between the board control logic (start/status) and the Gowin_SP instance.

Parameters:
- ADDR_W, 4, SRAM address width; DEPTH = 2**ADDR_W.
- DATA_W, 8, SRAM data width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE/DONE.
- verify_only  in  1  sampled with start; 1 = skip write phase.
- pattern_sel  in  2  sampled with start; 0 addr, 1 DEPTH-1-addr, 2 checkerboard, 3 seed^addr.
- seed  in  DATA_W  sampled with start; used by pattern 3.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at test end.
- pass  out  1  valid from done until next start; 1 iff err_count==0.
- err_count  out  ADDR_W+1  mismatches in the current/last run (max DEPTH, no saturation needed).
- first_err_addr  out  ADDR_W  address of the first mismatch; 0 if none.
- mem_ce, mem_wre, mem_oce, mem_reset  out  1 each  SRAM controls.
- mem_ad  out  ADDR_W  SRAM address.
- mem_din  out  DATA_W  SRAM write data.
- mem_dout  in  DATA_W  SRAM read data, 1-cycle read latency (bypass mode).

Behaviour:
- Reset values (reset_n low at an edge): state IDLE; busy 0, done 0, pass 0, err_count 0, first_err_addr 0, mem_ce 0, mem_wre 0, mem_ad 0, mem_din 0.
- Constant outputs: mem_oce = 1 and mem_reset = 0 at all times.
- All mem_* outputs are registered.
- States: IDLE -> WRITE -> READ -> DRAIN -> DONE -> (IDLE on next start).
- Start accepted at edge E0 in IDLE or DONE. The edge latches mode, pattern and seed, and clears err_count, first_err_addr and pass. start in WRITE/READ/DRAIN is ignored.
- WRITE: after edge E0+k (k=0..DEPTH-1), mem_ce=1, mem_wre=1, mem_ad=k, mem_din=pat(k).
- READ: entered after E0+DEPTH with mem_wre=0, mem_ce=1, mem_ad=j for j=0..DEPTH-1, one per cycle. With verify_only, READ starts directly after E0 and all later edges shift by -DEPTH.
- Compare: mem_dout for address j is valid in the cycle after it was presented. The compare is pipelined: expected value and address are delayed one stage and compared at the next edge.
- On mismatch, err_count increments. first_err_addr is captured only when err_count was 0.
- DRAIN: one cycle, mem_ce=0, holds the final compare. The last compare occurs at the edge that enters DONE.
- DONE: done=1 for exactly one cycle, busy=0, pass = (err_count==0). Results hold until the next start. State stays in DONE and still accepts start.
- Full-test timing: busy high after E0; done high after E0+2*DEPTH+1.
- Patterns (result truncated or zero-extended to DATA_W):
  - 0: addr
  - 1: DEPTH-1-addr
  - 2: addr[0] ? 0xAA.. : 0x55..
  - 3: seed ^ addr
- Address wrap: counter stops at DEPTH-1. It never wraps within a phase.
- Reset mid-run: immediate return to reset values at that edge. mem_ce/mem_wre drop the same edge, so no partial write follows.
- start coincident with reset_n low: reset wins.

Decomposition:
- Package sram_bist_pkg:
  - state enum (IDLE, WRITE, READ, DRAIN, DONE)
  - pattern codes PAT_ADDR=0, PAT_RADDR=1, PAT_CHK=2, PAT_SEED=3
- Sub-module sram_bist_patgen: combinational (pattern_sel, seed, addr) -> data. Instantiated twice: write data and delayed expected data.

Test Plan:
- Reset, then full test pattern 0 against a clean 16x8 SRAM model -> mem_din 0x00..0x0F on ad 0..15; done 33 cycles after start; pass=1, err_count=0.
- verify_only=1, pattern 1 on power-up contents (addr0=0x0F .. addr15=0x00) -> no writes (mem_wre stays 0); done 17 cycles after start; pass=1.
- Model with bit 3 stuck-at-0, pattern 2 -> 0x55/0xAA unaffected except where bit 3 is set (0xAA at odd addresses) -> err_count=8, first_err_addr=1, pass=0.
- Pattern 3, seed 0xA5, single corrupted word at addr 9 (verify_only) -> err_count=1, first_err_addr=9.
- start pulsed again mid-WRITE -> ignored, sequence and timing unchanged. reset_n low at READ cycle 5 -> next cycle mem_ce=0, busy=0, all status cleared.
- Back-to-back: start in the DONE cycle -> new run begins, pass/err_count cleared at that edge, done again 33 cycles later.
